// File: rtl/mem_sram_pkg.sv
// Shared types and helpers for the simple dual-port SRAM and its init controller.
package mem_sram_pkg;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

  localparam int BYTE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_sram_dp_if.sv
// Write/read bus of the dual-port SRAM; the client is the master, the memory the slave.
interface mem_sram_dp_if
  import mem_sram_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 32
);

  logic                        nWE;
  logic [A_WIDTH-1:0]          wr_addr;
  logic [D_WIDTH-1:0]          data_in;
  logic [D_WIDTH/BYTE_W-1:0]   byte_en;
  logic                        par_inj;
  logic                        nRE;
  logic [A_WIDTH-1:0]          rd_addr;
  logic [D_WIDTH-1:0]          data_out;
  logic                        rd_valid;
  logic                        init_busy;
  logic                        par_err;

  modport master (
    output nWE, wr_addr, data_in, byte_en, par_inj, nRE, rd_addr,
    input  data_out, rd_valid, init_busy, par_err
  );

  modport slave (
    input  nWE, wr_addr, data_in, byte_en, par_inj, nRE, rd_addr,
    output data_out, rd_valid, init_busy, par_err
  );

endinterface

// File: rtl/mem_sram_init_ctrl.sv
// Post-reset zero-fill sequencer: walks addresses 0..DEPTH-1, then parks in READY.
module mem_sram_init_ctrl
  import mem_sram_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 1 << A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  output logic               init_busy_o,
  output logic [A_WIDTH-1:0] init_addr_o
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

  init_state_e        state_q;
  logic [A_WIDTH-1:0] init_cnt_q;
  logic               init_busy_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + A_WIDTH'(1);
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY:   state_q <= READY;
        default: state_q <= INIT;
      endcase
    end
  end

  assign init_busy_o = init_busy_q;
  assign init_addr_o = init_cnt_q;

endmodule

// File: rtl/mem_sram_dp.sv
// Simple dual-port SRAM: byte-enabled writes, 1/2-cycle reads, zero-fill after reset.
// Optional per-byte even parity is enabled by defining MEM_SRAM_PARITY_EN.
module mem_sram_dp
  import mem_sram_pkg::*;
#(
  parameter int A_WIDTH  = 8,
  parameter int D_WIDTH  = 32,
  parameter int DEPTH    = 1 << A_WIDTH,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input logic           clk,
  input logic           rst,
  mem_sram_dp_if.slave  bus
);

  localparam int NB         = D_WIDTH / BYTE_W;
  localparam bit FULL_RANGE = (DEPTH == (1 << A_WIDTH));

  generate
    if (D_WIDTH % BYTE_W != 0) begin : g_bad_dwidth
      $error("mem_sram_dp: D_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (1 << A_WIDTH) || DEPTH < 1) begin : g_bad_depth
      $error("mem_sram_dp: DEPTH must be in 1..2**A_WIDTH");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rdlat
      $error("mem_sram_dp: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic               init_busy;
  logic [A_WIDTH-1:0] init_addr;

  mem_sram_init_ctrl #(
    .A_WIDTH (A_WIDTH),
    .DEPTH   (DEPTH)
  ) u_init_ctrl (
    .clk         (clk),
    .rst         (rst),
    .init_busy_o (init_busy),
    .init_addr_o (init_addr)
  );

  logic wr_in_range;
  logic rd_in_range;

  generate
    if (FULL_RANGE) begin : g_full_range
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_part_range
      assign wr_in_range = (int'(bus.wr_addr) < DEPTH);
      assign rd_in_range = (int'(bus.rd_addr) < DEPTH);
    end
  endgenerate

  logic wr_en;
  logic rd_accept;
  logic fwd_hit;

  assign wr_en     = !init_busy && !bus.nWE && wr_in_range;
  assign rd_accept = !init_busy && !bus.nRE;
  assign fwd_hit   = (WR_FIRST != 0) && wr_en && (bus.wr_addr == bus.rd_addr);

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch so it maps onto RAM macros; the init FSM zero-fills it instead.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem_q[init_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byte_en[i]) begin
          mem_q[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.data_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

`ifdef MEM_SRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (init_busy) begin
      par_q[init_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byte_en[i]) begin
          par_q[bus.wr_addr][i] <= byte_parity(bus.data_in[i*BYTE_W +: BYTE_W]) ^ bus.par_inj;
        end
      end
    end
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = bus.par_inj;
`endif

  logic [D_WIDTH-1:0] rd_word;
  logic               rd_perr;

  // NOTE: combinational blocks assign defaults first and use blocking (=) so no latch is inferred.
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (rd_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (fwd_hit && bus.byte_en[i]) begin
          rd_word[i*BYTE_W +: BYTE_W] = bus.data_in[i*BYTE_W +: BYTE_W];
        end else begin
          rd_word[i*BYTE_W +: BYTE_W] = mem_q[bus.rd_addr][i*BYTE_W +: BYTE_W];
`ifdef MEM_SRAM_PARITY_EN
          rd_perr = rd_perr |
                    (byte_parity(mem_q[bus.rd_addr][i*BYTE_W +: BYTE_W]) != par_q[bus.rd_addr][i]);
`endif
        end
      end
    end
  end

  logic               out_valid;
  logic               out_perr;
  logic [D_WIDTH-1:0] out_data;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic               s1_valid_q;
      logic               s1_perr_q;
      logic [D_WIDTH-1:0] s1_data_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_perr_q  <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_accept;
          if (rd_accept) begin
            s1_perr_q <= rd_perr;
            s1_data_q <= rd_word;
          end
        end
      end

      assign out_valid = s1_valid_q;
      assign out_perr  = s1_perr_q;
      assign out_data  = s1_data_q;
    end else begin : g_lat1
      assign out_valid = rd_accept;
      assign out_perr  = rd_perr;
      assign out_data  = rd_word;
    end
  endgenerate

  logic [D_WIDTH-1:0] data_out_q;
  logic               rd_valid_q;
  logic               par_err_q;

  // data_out holds the last result; rd_valid and par_err are single-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= out_valid;
      par_err_q  <= out_valid && out_perr;
      if (out_valid) begin
        data_out_q <= out_data;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = init_busy;
  assign bus.par_err   = par_err_q;

endmodule

// File: tb/tb_mem_sram_dp.sv
// Directed bench: dut1 = full depth, RD_LAT 1, write-first; dut2 = 200 words, RD_LAT 2, read-first.
module tb_mem_sram_dp;

`ifdef MEM_SRAM_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        nwe;
  logic        nre;
  logic        pinj;
  logic [7:0]  waddr;
  logic [7:0]  raddr;
  logic [31:0] din;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  mem_sram_dp_if #(.A_WIDTH(8), .D_WIDTH(32)) bus1 ();
  mem_sram_dp_if #(.A_WIDTH(8), .D_WIDTH(32)) bus2 ();

  assign bus1.nWE = nwe;   assign bus2.nWE = nwe;
  assign bus1.wr_addr = waddr; assign bus2.wr_addr = waddr;
  assign bus1.data_in = din;   assign bus2.data_in = din;
  assign bus1.byte_en = be;    assign bus2.byte_en = be;
  assign bus1.par_inj = pinj;  assign bus2.par_inj = pinj;
  assign bus1.nRE = nre;   assign bus2.nRE = nre;
  assign bus1.rd_addr = raddr; assign bus2.rd_addr = raddr;

  mem_sram_dp dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  mem_sram_dp #(
    .A_WIDTH  (8),
    .D_WIDTH  (32),
    .DEPTH    (200),
    .RD_LAT   (2),
    .WR_FIRST (0)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  logic [31:0] exp_b [3];
  logic [7:0]  adr_b [3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    nwe   = 1'b1;
    nre   = 1'b1;
    pinj  = 1'b0;
    waddr = '0;
    raddr = '0;
    din   = '0;
    be    = '0;
  endtask

  task automatic step();
    @(negedge clk);
    set_idle();
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic inj);
    nwe = 1'b0; waddr = a; din = d; be = m; pinj = inj;
    step();
  endtask

  // Inputs for the read (and any same-cycle write) are already applied by the caller.
  task automatic expect_read(input string tag, input logic [31:0] exp1, input logic [31:0] exp2,
                             input logic perr1, input logic perr2);
    step();
    check({tag, "_valid1"}, bus1.rd_valid, 1);
    check({tag, "_data1"},  bus1.data_out, exp1);
    check({tag, "_perr1"},  bus1.par_err,  perr1);
    check({tag, "_early2"}, bus2.rd_valid, 0);
    @(negedge clk);
    check({tag, "_drop1"},  bus1.rd_valid, 0);
    check({tag, "_hold1"},  bus1.data_out, exp1);
    check({tag, "_valid2"}, bus2.rd_valid, 1);
    check({tag, "_data2"},  bus2.data_out, exp2);
    check({tag, "_perr2"},  bus2.par_err,  perr2);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] a, input logic [31:0] exp1,
                             input logic [31:0] exp2, input logic perr1, input logic perr2);
    nre = 1'b0; raddr = a;
    expect_read(tag, exp1, exp2, perr1, perr2);
  endtask

  task automatic wait_init(input string tag);
    int n  = 0;
    int n1 = 0;
    int n2 = 0;
    while ((n1 == 0 || n2 == 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus1.init_busy && n1 == 0) n1 = n;
      if (!bus2.init_busy && n2 == 0) n2 = n;
    end
    check({tag, "_cycles1"}, n1, 256);
    check({tag, "_cycles2"}, n2, 200);
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data1",  bus1.data_out,  0);
    check("rst_valid1", bus1.rd_valid,  0);
    check("rst_busy1",  bus1.init_busy, 1);
    check("rst_perr1",  bus1.par_err,   0);
    check("rst_valid2", bus2.rd_valid,  0);
    check("rst_busy2",  bus2.init_busy, 1);

    rst = 1'b0;
    wait_init("init");
    read_expect("rd_init", 8'h22, 32'h0, 32'h0, 1'b0, 1'b0);

    write(8'h22, 32'h01234567, 4'b1111, 1'b0);
    write(8'h22, 32'hAABBCCDD, 4'b0101, 1'b0);
    read_expect("rd_merge", 8'h22, 32'h01BB45DD, 32'h01BB45DD, 1'b0, 1'b0);

    nwe = 1'b0; waddr = 8'h01; din = 32'h12345678; be = 4'b1111;
    nre = 1'b0; raddr = 8'h01;
    expect_read("rdw_same", 32'h12345678, 32'h00000000, 1'b0, 1'b0);
    read_expect("rdw_after", 8'h01, 32'h12345678, 32'h12345678, 1'b0, 1'b0);

    write(8'h14, 32'h5A5AA5A5, 4'b1111, 1'b0);
    exp_b[0] = 32'h12345678; adr_b[0] = 8'h01;
    exp_b[1] = 32'h5A5AA5A5; adr_b[1] = 8'h14;
    exp_b[2] = 32'h01BB45DD; adr_b[2] = 8'h22;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        nre = 1'b0; raddr = adr_b[c];
      end
      step();
      check($sformatf("b2b_valid1_%0d", c), bus1.rd_valid, (c < 3) ? 1 : 0);
      if (c < 3) check($sformatf("b2b_data1_%0d", c), bus1.data_out, exp_b[c]);
      check($sformatf("b2b_valid2_%0d", c), bus2.rd_valid, (c >= 1 && c <= 3) ? 1 : 0);
      if (c >= 1 && c <= 3) check($sformatf("b2b_data2_%0d", c), bus2.data_out, exp_b[c-1]);
    end

    write(8'hF0, 32'hDEADBEEF, 4'b1111, 1'b0);
    read_expect("oor", 8'hF0, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);

    write(8'h14, 32'h23456789, 4'b1111, 1'b1);
    read_expect("par_inj", 8'h14, 32'h23456789, 32'h23456789, PAR_ON, PAR_ON);
    write(8'h14, 32'h23456789, 4'b1111, 1'b0);
    read_expect("par_ok", 8'h14, 32'h23456789, 32'h23456789, 1'b0, 1'b0);

    nwe = 1'b0; waddr = 8'h30; din = 32'h0F0F0F0F; be = 4'b1111; pinj = 1'b1;
    nre = 1'b0; raddr = 8'h30;
    expect_read("par_fwd", 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0);
    read_expect("par_stored", 8'h30, 32'h0F0F0F0F, 32'h0F0F0F0F, PAR_ON, PAR_ON);

    nre = 1'b0; raddr = 8'h22;
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    check("mid_rst_valid2", bus2.rd_valid,  0);
    check("mid_rst_data2",  bus2.data_out,  0);
    check("mid_rst_valid1", bus1.rd_valid,  0);
    check("mid_rst_data1",  bus1.data_out,  0);
    check("mid_rst_busy1",  bus1.init_busy, 1);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_quiet2", bus2.rd_valid, 0);
    end
    rst = 1'b0;
    wait_init("reinit");
    read_expect("rd_rst_22", 8'h22, 32'h0, 32'h0, 1'b0, 1'b0);
    read_expect("rd_rst_14", 8'h14, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
